// File: rtl/ram_loader_pkg.sv
// ram_loader_pkg: shared states and widths for the RAM program loader (VERIFY only with RAM_LOADER_VERIFY_EN).
package ram_loader_pkg;
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
`ifdef RAM_LOADER_VERIFY_EN
    VERIFY,
`endif
    DONE
  } loader_state_e;
  localparam int LEN_W = 5;
  localparam int CKSUM_W = 8;
  localparam int RAM_ADDR_BITS = 4;
endpackage

// File: rtl/ram_loader_checksum_acc.sv
// checksum_acc: modulo-2^W running sum with synchronous clear.
module checksum_acc
  import ram_loader_pkg::*;
#(
  parameter int W = CKSUM_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] sum
);
  always_ff @(posedge clk or posedge rst)
    if (rst) sum <= '0;
    else if (clr) sum <= '0;
    else if (en) sum <= sum + d;
endmodule

// File: rtl/ram_loader.sv
// ram_loader: streams words into the RAM from address 0, halting the CPU; RAM_LOADER_VERIFY_EN adds checksum read-back.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MEM_SIZE = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [LEN_W-1:0]      i_len,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready,
  output logic                  o_we,
  output logic [DATA_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_bus_data,
  output logic                  o_jmp,
  input  logic [DATA_WIDTH-1:0] i_ram_data,
  output logic                  o_cpu_halt,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);
  loader_state_e state, next;
  logic [LEN_W-1:0] len, cnt;
  logic [CKSUM_W-1:0] wr_sum;
  logic legal, hs, last_wr, start_ok;
  assign legal = (i_len != '0) && (i_len <= LEN_W'(MEM_SIZE));
  assign o_ready = state == LOAD;
  assign hs = i_valid & o_ready;
  assign last_wr = cnt == len - 1'b1;
  assign start_ok = state == IDLE && i_start && legal;
  assign o_busy = state != IDLE;
  assign o_cpu_halt = o_busy;
  assign o_done = state == DONE;
  assign o_jmp = 1'b0;
  checksum_acc #(.W(CKSUM_W)) u_wr_sum (
    .clk(i_clk), .rst(i_rst), .clr(start_ok), .en(hs), .d(CKSUM_W'(i_data)), .sum(wr_sum)
  );
`ifdef RAM_LOADER_VERIFY_EN
  logic [CKSUM_W-1:0] rd_sum;
  logic rd_last;
  assign rd_last = LEN_W'(o_addr[RAM_ADDR_BITS-1:0]) == len - 1'b1;
  checksum_acc #(.W(CKSUM_W)) u_rd_sum (
    .clk(i_clk), .rst(i_rst), .clr(start_ok), .en(state == VERIFY), .d(CKSUM_W'(i_ram_data)), .sum(rd_sum)
  );
`else
  logic unused_rd;
  assign unused_rd = ^{i_ram_data, wr_sum};
`endif
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:   next = i_start ? (legal ? LOAD : DONE) : IDLE;
      LOAD:   next = (hs && last_wr) ? FLUSH : LOAD;
`ifdef RAM_LOADER_VERIFY_EN
      FLUSH:  next = VERIFY;
      VERIFY: next = rd_last ? DONE : VERIFY;
`else
      FLUSH:  next = DONE;
`endif
      DONE:   next = IDLE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      len <= '0;
      cnt <= '0;
      o_we <= 1'b0;
      o_addr <= '0;
      o_bus_data <= '0;
      o_err <= 1'b0;
    end else begin
      o_we <= hs;
      o_bus_data <= hs ? i_data : '0;
`ifdef RAM_LOADER_VERIFY_EN
      o_addr <= hs ? DATA_WIDTH'(cnt[RAM_ADDR_BITS-1:0]) :
                (state == VERIFY && !rd_last) ? o_addr + 1'b1 : '0;
`else
      o_addr <= hs ? DATA_WIDTH'(cnt[RAM_ADDR_BITS-1:0]) : '0;
`endif
      if (state == IDLE && i_start) begin
        len <= i_len;
        cnt <= '0;
        o_err <= !legal;
      end else if (hs) cnt <= cnt + 1'b1;
`ifdef RAM_LOADER_VERIFY_EN
      // Last read is still on i_ram_data, so it is folded in here rather than via rd_sum.
      if (state == VERIFY && rd_last && CKSUM_W'(rd_sum + CKSUM_W'(i_ram_data)) != wr_sum) o_err <= 1'b1;
`endif
    end
endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: table-driven load sessions against a behavioural RAM, plus reset and start-during-load sequences.
module tb_ram_loader;
  logic clk = 0, rst = 1;
  logic i_start = 0, i_valid = 0;
  logic [4:0] i_len = 0;
  logic [7:0] i_data = 0, i_ram_data;
  logic o_ready, o_we, o_jmp, o_cpu_halt, o_busy, o_done, o_err;
  logic [7:0] o_addr, o_bus_data;
  logic [7:0] mem [16];
  logic [7:0] pat [16];
  logic clear_req = 0, corrupt_req = 0;
  int total = 0, bad = 0;
`ifdef RAM_LOADER_VERIFY_EN
  localparam bit VER = 1;
`else
  localparam bit VER = 0;
`endif
  typedef struct {
    int len;
    bit gap;
    bit corrupt;
    bit poke;
    bit exp_err;
  } vec_t;
  vec_t vecs [8];

  always #5 clk = ~clk;

  ram_loader dut (
    .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_len(i_len), .i_valid(i_valid), .i_data(i_data),
    .o_ready(o_ready), .o_we(o_we), .o_addr(o_addr), .o_bus_data(o_bus_data), .o_jmp(o_jmp),
    .i_ram_data(i_ram_data), .o_cpu_halt(o_cpu_halt), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  assign i_ram_data = mem[o_addr[3:0]];
  always @(posedge clk) begin
    if (clear_req) for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
    if (o_we) mem[o_addr[3:0]] <= o_bus_data;
    if (corrupt_req) mem[1] <= 8'hFF;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string name);
    chk(name, int'({o_ready, o_we, o_addr, o_bus_data, o_jmp, o_cpu_halt, o_busy, o_done, o_err}), 0);
  endtask

  task automatic run(input vec_t v);
    int cyc, acc, wexp, late_ready, done_cyc, exp_done;
    bit err, legal;
    legal = v.len >= 1 && v.len <= 16;
    exp_done = legal ? v.len + 2 + (v.gap ? v.len - 1 : 0) + (VER ? v.len : 0) : 1;
    clear_req = 1;
    @(posedge clk); @(negedge clk);
    clear_req = 0;
    i_start = 1;
    i_len = 5'(v.len);
    @(posedge clk); @(negedge clk);
    i_start = 0;
    cyc = 1; acc = 0; wexp = 0; late_ready = 0; done_cyc = -1; err = 0;
    while (cyc < 300) begin
      i_valid = (acc < v.len) && (!v.gap || cyc[0]);
      i_data = pat[acc[3:0]];
      i_start = v.poke && cyc == 2;
      i_len = (v.poke && cyc == 2) ? 5'd2 : 5'(v.len);
      corrupt_req = v.corrupt && cyc == v.len + 2;
      #1;
      if (cyc == 1) chk("halt_c1", o_cpu_halt, 1);
      if (o_we) begin
        chk("wr_addr", o_addr, wexp);
        chk("wr_data", o_bus_data, pat[wexp[3:0]]);
        if (!v.gap) chk("wr_cycle", cyc, wexp + 2);
        wexp++;
      end
      if (acc >= v.len && o_ready) late_ready++;
      if (o_done) begin
        done_cyc = cyc;
        err = o_err;
        break;
      end
      if (i_valid && o_ready) acc++;
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    i_valid = 0; i_start = 0; corrupt_req = 0;
    chk("done_cycle", done_cyc, exp_done);
    chk("err_at_done", err, v.exp_err);
    chk("n_writes", wexp, legal ? v.len : 0);
    chk("ready_after_last", late_ready, 0);
    @(posedge clk); @(negedge clk);
    chk("idle_after", {o_busy, o_cpu_halt, o_done}, 0);
    chk("err_sticky", o_err, v.exp_err);
    if (legal && !v.corrupt) begin
      for (int i = 0; i < v.len; i++) chk("ram", mem[i], pat[i]);
      if (v.len < 16) chk("ram_no_extra", mem[v.len], 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) pat[i] = 8'(8'h1A + i * 8'h11);
    vecs[0] = '{4, 0, 0, 0, 0};
    vecs[1] = '{16, 1, 0, 0, 0};
    vecs[2] = '{0, 0, 0, 0, 1};
    vecs[3] = '{17, 0, 0, 0, 1};
    vecs[4] = '{3, 0, 1, 0, VER};
    vecs[5] = '{1, 0, 0, 0, 0};
    vecs[6] = '{5, 0, 0, 1, 0};
    vecs[7] = '{6, 1, 0, 0, 0};
    repeat (2) @(negedge clk);
    chk_zero("reset_state");
    rst = 0;
    @(negedge clk);
    chk_zero("idle_state");
    for (int n = 0; n < 8; n++) run(vecs[n]);
    i_start = 1; i_len = 5'd4;
    @(posedge clk); @(negedge clk);
    i_start = 0; i_valid = 1; i_data = pat[0];
    @(posedge clk); @(negedge clk);
    i_data = pat[1];
    @(posedge clk); @(negedge clk);
    i_valid = 0;
    chk("mid_load_we", o_we, 1);
    rst = 1;
    #1;
    chk_zero("mid_reset");
    @(negedge clk);
    rst = 0;
    run('{2, 0, 0, 0, 0});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
